// File: rtl/otter_branch_predictor_pkg.sv
// Shared types and constants for the OTTER branch target buffer.
// Optional feature macro used by the top: BP_GSHARE_EN (gshare-indexed lookup).
package otter_bp_pkg;

  // Tag storage is sized for the widest tag any legal configuration can use.
  // Narrower tags are stored zero-extended.
  localparam int BP_FIELD_W = 30;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;
  localparam logic [1:0] CTR_JUMP  = 2'b11;

  typedef enum logic {
    BP_BRANCH = 1'b0,
    BP_JAL    = 1'b1
  } bp_kind_t;

  typedef struct packed {
    logic                  valid;
    logic [BP_FIELD_W-1:0] tag;
    logic [29:0]           target;
    logic [1:0]            ctr;
    logic                  is_jump;
  } bp_entry_t;

  // Contents of an entry after reset: invalid, weakly not-taken.
  function automatic bp_entry_t bp_entry_reset();
    bp_entry_t e;
    e.valid   = 1'b0;
    e.tag     = {BP_FIELD_W{1'b0}};
    e.target  = 30'd0;
    e.ctr     = CTR_RESET;
    e.is_jump = 1'b0;
    return e;
  endfunction

  // Sequential fall-through address.
  function automatic logic [31:0] bp_pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/otter_branch_predictor_if.sv
// Fetch/execute-facing bus of the branch predictor.
// master = core side (drives lookups and resolutions), slave = predictor.
interface otter_branch_predictor_if #(
  parameter int IDX_W = 4
);

  logic             F_VALID;
  logic [31:0]      F_PC;
  logic             PRED_TAKEN;
  logic [31:0]      PRED_TARGET;
  logic [IDX_W-1:0] PRED_IDX;

  logic             U_VALID;
  logic             U_KIND;
  logic [31:0]      U_PC;
  logic [IDX_W-1:0] U_IDX;
  logic             U_TAKEN;
  logic [31:0]      U_TARGET;
  logic             U_PRED_TAKEN;
  logic [31:0]      U_PRED_TARGET;
  logic             MISPREDICT;
  logic [31:0]      REDIRECT_PC;

  logic             FLUSH_ALL;
  logic [31:0]      PERF_LOOKUPS;
  logic [31:0]      PERF_MISPRED;

  modport master (
    output F_VALID, F_PC,
    output U_VALID, U_KIND, U_PC, U_IDX, U_TAKEN, U_TARGET, U_PRED_TAKEN, U_PRED_TARGET,
    output FLUSH_ALL,
    input  PRED_TAKEN, PRED_TARGET, PRED_IDX,
    input  MISPREDICT, REDIRECT_PC,
    input  PERF_LOOKUPS, PERF_MISPRED
  );

  modport slave (
    input  F_VALID, F_PC,
    input  U_VALID, U_KIND, U_PC, U_IDX, U_TAKEN, U_TARGET, U_PRED_TAKEN, U_PRED_TARGET,
    input  FLUSH_ALL,
    output PRED_TAKEN, PRED_TARGET, PRED_IDX,
    output MISPREDICT, REDIRECT_PC,
    output PERF_LOOKUPS, PERF_MISPRED
  );

endinterface

// File: rtl/otter_branch_predictor_sat_counter.sv
// 2-bit saturating direction counter, next-state function only.
module bp_sat_counter (
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  // Count up on taken, down on not-taken, holding at 00 and 11.
  always_comb begin
    ctr_o = ctr_i;
    case (ctr_i)
      2'b00:   ctr_o = taken_i ? 2'b01 : 2'b00;
      2'b01:   ctr_o = taken_i ? 2'b10 : 2'b00;
      2'b10:   ctr_o = taken_i ? 2'b11 : 2'b01;
      2'b11:   ctr_o = taken_i ? 2'b11 : 2'b10;
      default: ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/otter_branch_predictor.sv
// Branch target buffer with 2-bit direction counters for the OTTER pipeline.
// Lookup and mispredict detection are combinational; the table, history and
// perf counters update on the clock edge.
// Optional feature: define BP_GSHARE_EN to XOR a global branch history into
// the fetch-side index.
module otter_branch_predictor
  import otter_bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 10
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  otter_branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_entry_t table_q [ENTRIES];
  bp_entry_t table_d [ENTRIES];

  logic [31:0] perf_lookups_q, perf_lookups_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;

  logic [IDX_W-1:0]      f_idx_s;
  logic [BP_FIELD_W-1:0] f_tag_s;
  bp_entry_t             f_entry_s;
  logic                  f_hit_s;
  logic                  pred_taken_s;

  bp_kind_t              u_kind_s;
  logic [BP_FIELD_W-1:0] u_tag_s;
  bp_entry_t             u_entry_s;
  logic                  u_hit_s;
  logic [1:0]            u_ctr_next_s;
  bp_entry_t             wr_entry_s;
  logic                  wr_en_s;
  logic                  mispredict_s;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  // Global history: shift in the resolved direction on every accepted BRANCH update.
  always_comb begin
    ghr_d = ghr_q;
    if (bp.FLUSH_ALL) begin
      ghr_d = {IDX_W{1'b0}};
    end else if (bp.U_VALID && (u_kind_s == BP_BRANCH)) begin
      ghr_d = {ghr_q[IDX_W-2:0], bp.U_TAKEN};
    end else begin
      ghr_d = ghr_q;
    end
  end

  // History register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ghr_q <= {IDX_W{1'b0}};
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign f_idx_s = bp.F_PC[IDX_W+1:2] ^ ghr_q;
`else
  assign f_idx_s = bp.F_PC[IDX_W+1:2];
`endif

  // Fetch-side lookup on the registered table; a same-cycle update is not visible.
  always_comb begin
    f_tag_s      = BP_FIELD_W'(bp.F_PC[IDX_W+2 +: TAG_W]);
    f_entry_s    = table_q[f_idx_s];
    f_hit_s      = f_entry_s.valid && (f_entry_s.tag == f_tag_s);
    pred_taken_s = bp.F_VALID && f_hit_s && (f_entry_s.is_jump || f_entry_s.ctr[1]);
  end

  assign bp.PRED_TAKEN  = pred_taken_s;
  assign bp.PRED_TARGET = pred_taken_s ? {f_entry_s.target, 2'b00} : bp_pc_plus4(bp.F_PC);
  assign bp.PRED_IDX    = f_idx_s;

  // Resolution check: wrong direction, or taken to a different target than predicted.
  always_comb begin
    mispredict_s = bp.U_VALID &&
                   ((bp.U_PRED_TAKEN != bp.U_TAKEN) ||
                    (bp.U_TAKEN && (bp.U_PRED_TARGET != bp.U_TARGET)));
  end

  assign bp.MISPREDICT  = mispredict_s;
  assign bp.REDIRECT_PC = bp.U_TAKEN ? bp.U_TARGET : bp_pc_plus4(bp.U_PC);

  assign u_kind_s  = bp_kind_t'(bp.U_KIND);
  assign u_tag_s   = BP_FIELD_W'(bp.U_PC[IDX_W+2 +: TAG_W]);
  assign u_entry_s = table_q[bp.U_IDX];
  assign u_hit_s   = u_entry_s.valid && (u_entry_s.tag == u_tag_s);

  bp_sat_counter u_sat_counter (
    .ctr_i   (u_entry_s.ctr),
    .taken_i (bp.U_TAKEN),
    .ctr_o   (u_ctr_next_s)
  );

  // Build the entry to write back at U_IDX and decide whether it is written.
  always_comb begin
    wr_entry_s = u_entry_s;
    wr_en_s    = 1'b0;
    if (bp.U_VALID) begin
      case (u_kind_s)
        BP_JAL: begin
          wr_entry_s.valid   = 1'b1;
          wr_entry_s.tag     = u_tag_s;
          wr_entry_s.target  = bp.U_TARGET[31:2];
          wr_entry_s.ctr     = CTR_JUMP;
          wr_entry_s.is_jump = 1'b1;
          wr_en_s            = 1'b1;
        end
        BP_BRANCH: begin
          if (u_hit_s) begin
            wr_entry_s.ctr = u_ctr_next_s;
            if (bp.U_TAKEN) begin
              wr_entry_s.target = bp.U_TARGET[31:2];
            end else begin
              wr_entry_s.target = u_entry_s.target;
            end
            wr_en_s = 1'b1;
          end else if (bp.U_TAKEN) begin
            wr_entry_s.valid   = 1'b1;
            wr_entry_s.tag     = u_tag_s;
            wr_entry_s.target  = bp.U_TARGET[31:2];
            wr_entry_s.ctr     = CTR_ALLOC;
            wr_entry_s.is_jump = 1'b0;
            wr_en_s            = 1'b1;
          end else begin
            wr_en_s = 1'b0;
          end
        end
        default: begin
          wr_en_s = 1'b0;
        end
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Next table: a flush clears every valid bit and drops any same-cycle update.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      table_d[i] = table_q[i];
    end
    if (bp.FLUSH_ALL) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_d[i].valid = 1'b0;
      end
    end else if (wr_en_s) begin
      table_d[bp.U_IDX] = wr_entry_s;
    end else begin
      table_d[bp.U_IDX] = table_q[bp.U_IDX];
    end
  end

  // Table storage; reset discards whatever update is presented in that cycle.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= bp_entry_reset();
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

  // Free-running perf counters; they wrap naturally at 2^32.
  always_comb begin
    perf_lookups_d = perf_lookups_q + {31'd0, bp.F_VALID};
    perf_mispred_d = perf_mispred_q + {31'd0, mispredict_s};
  end

  // Perf counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      perf_lookups_q <= 32'd0;
      perf_mispred_q <= 32'd0;
    end else begin
      perf_lookups_q <= perf_lookups_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  assign bp.PERF_LOOKUPS = perf_lookups_q;
  assign bp.PERF_MISPRED = perf_mispred_q;

endmodule

// File: doc/otter_branch_predictor.md
# otter_branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined OTTER core. It sits beside the fetch stage and predicts taken/not-taken and the target for BRANCH and JAL each fetch cycle. It takes resolution results back from execute and raises a mispredict and redirect so the hazard logic can flush younger stages. Without it, the pipeline always fetches PC+4 and pays a flush on every taken control transfer.

## Interface
Parameters:
- ENTRIES, 16, table depth; power of two, at least 4; IDX_W = $clog2(ENTRIES)
- TAG_W, 10, stored tag width; tag = PC[IDX_W+2 +: TAG_W]

Ports:
- CLK  in  1  single clock
- RESET_N  in  1  reset, synchronous, active-low
- F_VALID  in  1  fetch lookup valid; deasserted while the pipeline is stalled
- F_PC  in  32  fetch PC
- PRED_TAKEN  out  1  predicted taken for F_PC
- PRED_TARGET  out  32  predicted next PC: target if taken, else F_PC+4
- PRED_IDX  out  IDX_W  table index used; carried down the pipe and returned as U_IDX
- U_VALID  in  1  execute-stage resolution valid
- U_KIND  in  1  0 = BRANCH, 1 = JAL; JALR is never reported
- U_PC  in  32  resolved instruction PC
- U_IDX  in  IDX_W  PRED_IDX captured at fetch
- U_TAKEN  in  1  actual direction
- U_TARGET  in  32  actual taken target
- U_PRED_TAKEN  in  1  prediction carried from fetch
- U_PRED_TARGET  in  32  PRED_TARGET carried from fetch
- MISPREDICT  out  1  flush request
- REDIRECT_PC  out  32  correct next PC
- FLUSH_ALL  in  1  invalidate the whole table, e.g. fence.i
- PERF_LOOKUPS  out  32  count of F_VALID cycles
- PERF_MISPRED  out  32  count of MISPREDICT cycles

## Operation
- Each entry holds valid, tag[TAG_W], target[31:2], ctr[1:0] and is_jump.
- Lookup is combinational on the registered table.
  - hit = valid && tag match.
  - PRED_TAKEN = F_VALID && hit && (is_jump || ctr[1]).
- MISPREDICT = U_VALID && (U_PRED_TAKEN != U_TAKEN || (U_TAKEN && U_PRED_TARGET != U_TARGET)).
- REDIRECT_PC = U_TAKEN ? U_TARGET : U_PC+4.
- Table update on the clock edge after U_VALID, at entry U_IDX:
  - JAL: write valid=1, tag, target, is_jump=1, ctr=11.
  - BRANCH, tag hit: counter saturates up on taken, down on not-taken, 00..11; target rewritten when taken.
  - BRANCH, tag miss or invalid, taken: allocate/replace with ctr=10, is_jump=0.
  - BRANCH, tag miss, not-taken: no change.
- Perf counters wrap at 2^32. PERF_MISPRED increments on MISPREDICT whether or not the update is dropped.

## Timing
- Prediction latency 0 cycles: outputs are valid in the same cycle as F_PC.
- Mispredict latency 0 cycles from U_VALID.
- Update is visible to lookups from the cycle after U_VALID.
- Same-cycle lookup and update of the same index: the lookup sees the old contents.
- FLUSH_ALL: all valid bits (and GHR when configured) are cleared at the edge. It wins over a same-cycle update, which is dropped. MISPREDICT and REDIRECT_PC still assert combinationally.
- Reset, RESET_N low at an edge, including mid-operation:
  - all valid=0, ctr=01, GHR=0, perf counters=0
  - any U_VALID in that cycle is discarded
- Outputs after reset: PRED_TAKEN=0, PRED_TARGET=F_PC+4, MISPREDICT follows its inputs.

## Configuration
- BP_GSHARE_EN defined:
  - adds an IDX_W-bit global history register, shifted left with U_TAKEN on each BRANCH update and not on JAL
  - PRED_IDX = F_PC[IDX_W+1:2] ^ GHR
  - updates use U_IDX, so index skew between fetch and execute is harmless
- BP_GSHARE_EN undefined: PRED_IDX = F_PC[IDX_W+1:2]; no GHR.

## Structure
- Shared package otter_bp_pkg holds:
  - bp_entry_t packed struct
  - bp_kind_t enum (BP_BRANCH=0, BP_JAL=1)
  - ctr reset and allocate constants CTR_RESET=2'b01, CTR_ALLOC=2'b10
- One sub-module, bp_sat_counter: 2-bit saturating next-state function, instantiated once on the update path.

## Test plan
ENTRIES=16, TAG_W=10, gshare off. PC 0x100 has index 0 and tag 4; PC 0x140 has index 0 and tag 5.
- After reset, lookup F_PC=0x100 -> PRED_TAKEN=0, PRED_TARGET=0x104, PRED_IDX=0.
- BRANCH update U_PC=0x100, taken, U_TARGET=0x80, U_PRED_TAKEN=0 -> MISPREDICT=1, REDIRECT_PC=0x80. Next cycle, lookup 0x100 -> PRED_TAKEN=1, PRED_TARGET=0x80.
- Continuing, BRANCH 0x100 not-taken with U_PRED_TAKEN=1, U_PRED_TARGET=0x80 -> MISPREDICT=1, REDIRECT_PC=0x104. Counter goes to 01, and the next lookup gives PRED_TAKEN=0.
- Aliasing: with 0x100 allocated taken, lookup 0x140 -> PRED_TAKEN=0. A taken update for 0x140 replaces the entry, and lookup 0x100 then misses.
- JAL U_PC=0x200 to 0x400 -> lookup 0x200 gives taken to 0x400. FLUSH_ALL together with a BRANCH update -> both 0x200 and the update target miss next cycle; PERF_MISPRED still increments.
- RESET_N low for one cycle with U_VALID=1 and taken -> no allocation, both perf counters read 0, and lookup of U_PC predicts not-taken.
